// File: rtl/gray_stream_converter_if.sv
// Stream bundle for gray_stream_converter.
//   byte_in/byte_valid/byte_ready : byte-serial R,G,B input (producer -> converter)
//   pix_out/pix_eol/pix_eof/pix_valid/pix_ready : gray pixel output (converter -> consumer)
// Modports: master = the side that produces bytes and consumes pixels; slave = the converter.
interface gray_stream_converter_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] pix_out;
  logic       pix_eol;
  logic       pix_eof;
  logic       pix_valid;
  logic       pix_ready;

  modport master (
    output byte_in, byte_valid, pix_ready,
    input  byte_ready, pix_out, pix_eol, pix_eof, pix_valid
  );

  modport slave (
    input  byte_in, byte_valid, pix_ready,
    output byte_ready, pix_out, pix_eol, pix_eof, pix_valid
  );
endinterface

// File: rtl/gray_stream_converter.sv
// gray_stream_converter: reassembles byte-serial R,G,B pixels and converts each one to 8-bit luma,
// Y = (77R + 150G + 29B) >> 8, delivered through a small output FIFO tagged with end-of-line and
// end-of-frame.
// Optional feature: define GRAY_ROUND_EN to round half up, Y = (S + 128) >> 8; otherwise truncate.
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   frame_start 1-cycle pulse, arms a new frame (only honoured in IDLE)
//   bus         slave side of gray_stream_converter_if (byte input / pixel output handshakes)
//   frame_done  1-cycle pulse once the frame's last pixel has left the FIFO
//   busy        high whenever the FSM is not IDLE
module gray_stream_converter #(
  parameter int unsigned WIDTH      = 350,
  parameter int unsigned HEIGHT     = 350,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  gray_stream_converter_if.slave  bus,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
  localparam logic [CntW:0]   DepthLim = (CntW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  // Byte capture
  logic [1:0]      phase_q;
  logic [7:0]      r_q, g_q, b_q;
  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;

  // calc stage: all three bytes latched, luma computed from them on the next edge
  logic            calc_valid_q, calc_eol_q, calc_eof_q;
  // pipe stage: registered result, pushed into the FIFO on the next edge
  logic            pipe_valid_q, pipe_eol_q, pipe_eof_q;
  logic [7:0]      pipe_pix_q;

  // FIFO entries are {eof, eol, pix}
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [9:0]      head;

  logic            accept, b_accept, last_col, last_pix;
  logic            push, pop, fifo_empty, pipeline_empty;
  logic [CntW:0]   in_flight;
  logic [16:0]     sum, sum_adj;
  logic [7:0]      luma;

  // Handshake and datapath decode
  always_comb begin
    fifo_empty     = (count_q == '0);
    in_flight      = {1'b0, count_q} + {{CntW{1'b0}}, pipe_valid_q};
    // Registers only: pix_ready never reaches byte_ready combinationally.
    bus.byte_ready = (state_q == StRun) && (in_flight < DepthLim);
    accept         = bus.byte_valid && bus.byte_ready;
    b_accept       = accept && (phase_q == 2'd2);
    last_col       = (col_q == ColLast);
    last_pix       = last_col && (row_q == RowLast);
    push           = pipe_valid_q;
    pop            = !fifo_empty && bus.pix_ready;
    pipeline_empty = fifo_empty && !pipe_valid_q && !calc_valid_q;
    busy           = (state_q != StIdle);

    // Max 77*255 + 150*255 + 29*255 = 65280, fits 17 bits even after +128.
    sum = 17'(r_q) * 17'd77 + 17'(g_q) * 17'd150 + 17'(b_q) * 17'd29;
`ifdef GRAY_ROUND_EN
    sum_adj = sum + 17'd128;
`else
    sum_adj = sum;
`endif
    luma = 8'(sum_adj >> 8);
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle:  if (frame_start) state_d = StRun;
      StRun:   if (b_accept && last_pix) state_d = StDrain;
      StDrain: begin
        // Both pipeline stages must be empty too, or the last pixel could still be in flight.
        if (pipeline_empty) begin
          state_d    = StIdle;
          frame_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Byte capture, position counters and the two result stages
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= 2'd0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      calc_valid_q <= 1'b0;
      calc_eol_q   <= 1'b0;
      calc_eof_q   <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_pix_q   <= '0;
      pipe_eol_q   <= 1'b0;
      pipe_eof_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && frame_start) begin
        phase_q <= 2'd0;
        col_q   <= '0;
        row_q   <= '0;
      end

      if (accept) begin
        unique case (phase_q)
          2'd0: begin
            r_q     <= bus.byte_in;
            phase_q <= 2'd1;
          end
          2'd1: begin
            g_q     <= bus.byte_in;
            phase_q <= 2'd2;
          end
          default: begin
            b_q     <= bus.byte_in;
            phase_q <= 2'd0;
          end
        endcase
      end

      calc_valid_q <= b_accept;
      if (b_accept) begin
        calc_eol_q <= last_col;
        calc_eof_q <= last_pix;
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end

      pipe_valid_q <= calc_valid_q;
      if (calc_valid_q) begin
        pipe_pix_q <= luma;
        pipe_eol_q <= calc_eol_q;
        pipe_eof_q <= calc_eof_q;
      end
    end
  end

  // Output FIFO control. byte_ready keeps count + pipe below depth, so push never overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pipe_eof_q, pipe_eol_q, pipe_pix_q};
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    bus.pix_valid = !fifo_empty;
    bus.pix_out   = fifo_empty ? 8'd0 : head[7:0];
    bus.pix_eol   = !fifo_empty && head[8];
    bus.pix_eof   = !fifo_empty && head[9];
  end

endmodule

// File: tb/tb_gray_stream_converter.sv
// Scoreboard bench for gray_stream_converter on a 4x2 frame with a 4-entry FIFO.
// Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
module tb_gray_stream_converter;
  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_start = 1'b0;
  logic frame_done, busy;

  gray_stream_converter_if bus_if ();

  gray_stream_converter #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .bus        (bus_if),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  typedef struct packed {
    logic [7:0] pix;
    logic       eol;
    logic       eof;
  } exp_t;
  exp_t exp_q[$];

  // Hand-computed vectors: S = 77R+150G+29B, trunc = S>>8, round = (S+128)>>8
  logic [7:0] vr  [8] = '{8'd255, 8'd255, 8'd0,   8'd0,  8'd0, 8'd100, 8'd10, 8'd128};
  logic [7:0] vg  [8] = '{8'd255, 8'd0,   8'd255, 8'd0,  8'd0, 8'd50,  8'd20, 8'd128};
  logic [7:0] vb  [8] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0, 8'd200, 8'd30, 8'd128};
  logic [7:0] vtr [8] = '{8'd255, 8'd76,  8'd149, 8'd28, 8'd0, 8'd82,  8'd18, 8'd128};
  logic [7:0] vrn [8] = '{8'd255, 8'd77,  8'd149, 8'd29, 8'd0, 8'd82,  8'd18, 8'd128};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int k, input int idx);
    exp_t e;
`ifdef GRAY_ROUND_EN
    e.pix = vrn[k];
`else
    e.pix = vtr[k];
`endif
    e.eol = ((idx % W) == W - 1);
    e.eof = (idx == W * H - 1);
    exp_q.push_back(e);
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus_if.byte_in    = b;
    bus_if.byte_valid = 1'b1;
    while (!bus_if.byte_ready && n <= 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n > 200) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got 0, expected 1");
    end
    @(posedge clk);
    #1;
    bus_if.byte_valid = 1'b0;
  endtask

  task automatic send_pixel(input int k, input int idx);
    push_exp(k, idx);
    send_byte(vr[k]);
    send_byte(vg[k]);
    send_byte(vb[k]);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_frames);
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got 0, expected 1");
    end
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 0);
    chk("busy_after_done", busy, 0);
    @(posedge clk);
    #1;
    chk("frame_done_count", fd_count, exp_frames);
  endtask

  // Monitor: every valid cycle the head must equal the oldest expected pixel; pop on transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.pix_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0d, expected none", bus_if.pix_out);
        end else begin
          chk("pix_out", bus_if.pix_out, exp_q[0].pix);
          chk("pix_eol", bus_if.pix_eol, exp_q[0].eol);
          chk("pix_eof", bus_if.pix_eof, exp_q[0].eof);
          if (bus_if.pix_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_done) begin
        fd_count++;
        chk("frame_done_pix_valid", bus_if.pix_valid, 0);
        chk("frame_done_queue_left", exp_q.size(), 0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, bus_if.byte_ready, 0);
    chk({tag, "_pix_valid"}, bus_if.pix_valid, 0);
    chk({tag, "_pix_out"}, bus_if.pix_out, 0);
    chk({tag, "_pix_eol"}, bus_if.pix_eol, 0);
    chk({tag, "_pix_eof"}, bus_if.pix_eof, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    bus_if.byte_in    = 8'd0;
    bus_if.byte_valid = 1'b0;
    bus_if.pix_ready  = 1'b1;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Frame 1: latency on the first pixel, then continuous bytes
    start_frame();
    chk("busy_in_run", busy, 1);
    push_exp(0, 0);
    send_byte(vr[0]);
    send_byte(vg[0]);
    send_byte(vb[0]);
    @(negedge clk);
    chk("latency_edge_n", bus_if.pix_valid, 0);
    @(negedge clk);
    chk("latency_edge_n1", bus_if.pix_valid, 0);
    @(negedge clk);
    chk("latency_edge_n2", bus_if.pix_valid, 1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 8; i++) send_pixel(i, i);
    wait_done(1);

    // Frame 2: consumer stalled, FIFO fills and back-pressures the byte input
    bus_if.pix_ready = 1'b0;
    start_frame();
    for (int i = 0; i < 4; i++) send_pixel(7 - i, i);
    push_exp(3, 4);
    send_byte(vr[3]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stall_byte_ready", bus_if.byte_ready, 0);
    chk("stall_pix_valid", bus_if.pix_valid, 1);
    @(posedge clk);
    #1;
    fork
      begin
        send_byte(vg[3]);
        send_byte(vb[3]);
        for (int i = 5; i < 8; i++) send_pixel(7 - i, i);
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        bus_if.pix_ready = 1'b1;
      end
    join
    wait_done(2);

    // Frame 3: reset after the G byte of pixel 5
    start_frame();
    for (int i = 0; i < 5; i++) send_pixel((i + 2) % 8, i);
    push_exp(6, 5);
    send_byte(vr[6]);
    send_byte(vg[6]);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Frame 4: fresh frame from (0,0) with a stray frame_start mid-run
    start_frame();
    for (int i = 0; i < 3; i++) send_pixel((i + 5) % 8, i);
    start_frame();
    for (int i = 3; i < 8; i++) send_pixel((i + 5) % 8, i);
    wait_done(3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
